// File: rtl/conv2_pkg.sv
// Shared geometry and types for the 3-channel 5x5 window buffer.
// Imported by conv2_line_shift and conv2_buf_3ch.
package conv2_pkg;

  localparam int IMG_W     = 12;
  localparam int IMG_H     = 12;
  localparam int KSZ       = 5;
  localparam int PIX_W     = 12;
  localparam int TAP_DEPTH = (KSZ - 1) * IMG_W + KSZ;
  localparam int WIN_N     = KSZ * KSZ;
  localparam int WIN_W     = WIN_N * PIX_W;
  localparam int POS_W     = 4;
  localparam int CNT_W     = 6;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    pos_t row;
    pos_t col;
  } rc_t;

  localparam pos_t LAST_COL = pos_t'(IMG_W - 1);
  localparam pos_t LAST_ROW = pos_t'(IMG_H - 1);
  localparam pos_t KOFF     = pos_t'(KSZ - 1);

  // Chain entry 0 is the newest pixel, so window element k sits this
  // many accepted pixels back in raster order.
  function automatic int tap_of(int k);
    return (KSZ - 1 - k / KSZ) * IMG_W + (KSZ - 1 - k % KSZ);
  endfunction

endpackage

// File: rtl/conv2_line_shift.sv
// One channel: raster shift chain with fixed 5x5 tap extraction.
// Shifts only when shift_en is high.
module conv2_line_shift
  import conv2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] din,
  output logic [WIN_W-1:0] win
);

  logic [PIX_W-1:0] chain [TAP_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAP_DEPTH; i++) begin
        chain[i] <= '0;
      end
    end else if (shift_en) begin
      chain[0] <= din;
      for (int i = 1; i < TAP_DEPTH; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  for (genvar k = 0; k < WIN_N; k++) begin : g_tap
    assign win[k*PIX_W +: PIX_W] = chain[tap_of(k)];
  end

endmodule

// File: rtl/conv2_buf_3ch.sv
// 3-channel 12x12 raster to 5x5 window buffer with shared row/col control.
// Optional win_cnt output enabled by CONV2_BUF_WIN_CNT_EN.
module conv2_buf_3ch
  import conv2_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [PIX_W-1:0] data_in1,
  input  logic signed [PIX_W-1:0] data_in2,
  input  logic signed [PIX_W-1:0] data_in3,
  output logic [WIN_W-1:0]        win1,
  output logic [WIN_W-1:0]        win2,
  output logic [WIN_W-1:0]        win3,
  output logic                    valid_out_buf,
  output logic                    frame_done
`ifdef CONV2_BUF_WIN_CNT_EN
  ,
  output logic [CNT_W-1:0]        win_cnt
`endif
);

  rc_t  pos;
  rc_t  pos_nxt;
  logic win_hit;
  logic frame_end;

  always_comb begin
    pos_nxt = pos;
    if (pos.col == LAST_COL) begin
      pos_nxt.col = '0;
      if (pos.row == LAST_ROW) begin
        pos_nxt.row = '0;
      end else begin
        pos_nxt.row = pos.row + pos_t'(1);
      end
    end else begin
      pos_nxt.col = pos.col + pos_t'(1);
    end
  end

  // A window exists only once a full 5x5 block lies left/above the pixel.
  assign win_hit   = valid_in && (pos.row >= KOFF) && (pos.col >= KOFF);
  assign frame_end = valid_in && (pos.row == LAST_ROW) && (pos.col == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos           <= '0;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      if (valid_in) begin
        pos <= pos_nxt;
      end
      valid_out_buf <= win_hit;
      frame_done    <= frame_end;
    end
  end

`ifdef CONV2_BUF_WIN_CNT_EN
  // Shows the index of the window currently on win* while it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (frame_done) begin
      win_cnt <= '0;
    end else if (valid_out_buf) begin
      win_cnt <= win_cnt + cnt_t'(1);
    end
  end
`endif

  conv2_line_shift u_ch1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (valid_in),
    .din      (data_in1),
    .win      (win1)
  );

  conv2_line_shift u_ch2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (valid_in),
    .din      (data_in2),
    .win      (win2)
  );

  conv2_line_shift u_ch3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (valid_in),
    .din      (data_in3),
    .win      (win3)
  );

endmodule

// File: doc/conv2_buf_3ch.md
CONV2_BUF_3CH -- requirements
Module: conv2_buf_3ch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port valid_in, input, 1, pixel triple accepted this cycle when high.
REQ-004 SHALL have ports data_in1/data_in2/data_in3, input, 12 signed each, one pixel per channel, raster order.
REQ-005 SHALL have ports win1/win2/win3, output, 300 each, 5x5 window per channel, element k = r*5+c at bits [12k+11:12k].
REQ-006 SHALL have port valid_out_buf, output, 1, single-cycle pulse marking a new window on win1..3.
REQ-007 SHALL have port frame_done, output, 1, single-cycle pulse with the last window of a frame.

Function
REQ-008 SHALL treat each frame as 12x12 pixels per channel, 5x5 kernel, 64 windows per frame (8x8 outputs).
REQ-009 SHALL hold per channel a 53-entry shift chain ((K-1)*W+K) that shifts by one only on valid_in high.
REQ-010 SHALL keep col (0..11) and row (0..11) counters of the pixel being accepted, advancing only on valid_in.
REQ-011 SHALL wrap col 11->0 with row+1, and col 11/row 11 -> col 0/row 0 (next frame), no idle cycle required.
REQ-012 SHALL assert valid_out_buf exactly one cycle after accepting a pixel with row>=4 and col>=4, low otherwise.
REQ-013 SHALL present on win* during valid_out_buf the window whose element 0 is pixel (row-4,col-4) and element 24 is the just-accepted pixel (row,col).
REQ-014 SHALL hold win* stable until the next accepted pixel; outputs may change without valid_out_buf, which the consumer ignores.
REQ-015 SHALL assert frame_done in the same cycle as valid_out_buf for the window ending at (11,11).
REQ-016 SHALL not emit windows spanning a row boundary (col<4 produces no valid).
REQ-017 SHALL tolerate arbitrary valid_in gaps; latency from accepted pixel to valid_out_buf is always 1 cycle.
REQ-018 SHALL pass data unmodified (no arithmetic, no saturation); sign preserved bit-exact.

Reset
REQ-019 SHALL on rst_n low clear row, col, valid_out_buf, frame_done and all shift-chain entries (win* = 0) immediately.
REQ-020 SHALL on reset mid-frame discard the partial frame; first pixel after release is (0,0).

Configuration
REQ-021 SHALL, with CONV2_BUF_WIN_CNT_EN defined, add output win_cnt [5:0]: windows emitted in current frame, incremented with each valid_out_buf, cleared with frame_done cycle's next accepted pixel and on reset.
REQ-022 SHALL, without CONV2_BUF_WIN_CNT_EN, omit win_cnt port and its logic; all other behaviour identical.

Structure
REQ-023 SHALL take IMG_W=12, IMG_H=12, KSZ=5, PIX_W=12, TAP_DEPTH=53 from shared package conv2_pkg.
REQ-024 SHALL implement the per-channel shift chain and tap extraction as sub-module conv2_line_shift, instanced three times.
REQ-025 SHALL share one row/col control across the three channels.

Verification
REQ-026 Ramp ch1 pixel=row*12+col, continuous valid_in -> first valid_out_buf one cycle after pixel 52; win1 elem0=0, elem4=4, elem20=48, elem24=52.
REQ-027 Full frame continuous -> exactly 64 valid_out_buf pulses, frame_done once with win1 elem24=143, elem0=91.
REQ-028 ch2=-(ramp), ch3=0x800 constant -> win2 elem24=-52 (0xFCC), win3 all elems 0x800; bit-exact.
REQ-029 valid_in toggled 1-0-0-1 randomly -> same 64 windows in same order, each pulse 1 cycle after its accepting pixel.
REQ-030 Assert rst_n low after 70 pixels, release, stream full frame -> outputs 0 during reset, then 64 correct windows, first matches REQ-026.
REQ-031 Two back-to-back frames, CONV2_BUF_WIN_CNT_EN defined -> 128 pulses, win_cnt reaches 63 then restarts 0..63, frame_done twice.
